// File: rtl/cordic_pkg.sv
// Shared CORDIC constants: binary-angle arctangent table, quadrant offsets, FSM states.
package cordic_pkg;

  localparam int unsigned ANGLE_W = 32;
  localparam int unsigned ATAN_N  = 31;
  localparam int unsigned SHIFT_W = 5;

  // atan(2^-i) scaled so that 2^32 is a full turn, rounded to nearest
  localparam logic [ANGLE_W-1:0] ATAN_TABLE [ATAN_N] = '{
    32'h2000_0000, 32'h12E4_051E, 32'h09FB_385B, 32'h0511_11D4,
    32'h028B_0D43, 32'h0145_D7E1, 32'h00A2_F61E, 32'h0051_7C55,
    32'h0028_BE53, 32'h0014_5F2F, 32'h000A_2F98, 32'h0005_17CC,
    32'h0002_8BE6, 32'h0001_45F3, 32'h0000_A2FA, 32'h0000_517D,
    32'h0000_28BE, 32'h0000_145F, 32'h0000_0A30, 32'h0000_0518,
    32'h0000_028C, 32'h0000_0146, 32'h0000_00A3, 32'h0000_0051,
    32'h0000_0029, 32'h0000_0014, 32'h0000_000A, 32'h0000_0005,
    32'h0000_0003, 32'h0000_0001, 32'h0000_0001
  };

  localparam logic [ANGLE_W-1:0] QUAD_90  = 32'h4000_0000;
  localparam logic [ANGLE_W-1:0] QUAD_270 = 32'hC000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Table lookup that returns zero past the last entry instead of indexing out of range
  function automatic logic [ANGLE_W-1:0] atan_lut(input logic [SHIFT_W-1:0] idx);
    logic [ANGLE_W-1:0] val;
    val = '0;
    if (32'(idx) < ATAN_N) val = ATAN_TABLE[idx];
    return val;
  endfunction

endpackage

// File: rtl/cordic_vectoring_if.sv
// Handshake bus for the vectoring CORDIC: input vector channel and magnitude/phase result channel.
interface cordic_vectoring_if #(
  parameter int unsigned WIDTH = 32
);
  import cordic_pkg::*;

  logic                      in_valid;
  logic                      in_ready;
  logic signed [WIDTH-1:0]   x_in;
  logic signed [WIDTH-1:0]   y_in;
  logic                      out_valid;
  logic                      out_ready;
  logic        [WIDTH+1:0]   mag_out;
  logic        [ANGLE_W-1:0] angle_out;

  modport master (
    output in_valid, x_in, y_in, out_ready,
    input  in_ready, out_valid, mag_out, angle_out
  );

  modport slave (
    input  in_valid, x_in, y_in, out_ready,
    output in_ready, out_valid, mag_out, angle_out
  );

endinterface

// File: rtl/cordic_micro_rot.sv
// One combinational CORDIC micro-rotation, usable by both vectoring and rotation modes.
// i_dir=1 rotates the vector clockwise and accumulates +atan; i_dir=0 the opposite.
module cordic_micro_rot
  import cordic_pkg::*;
#(
  parameter int unsigned XY_W = 34
) (
  input  logic signed [XY_W-1:0]    i_x,
  input  logic signed [XY_W-1:0]    i_y,
  input  logic        [ANGLE_W-1:0] i_z,
  input  logic        [SHIFT_W-1:0] i_shift,
  input  logic                      i_dir,
  output logic signed [XY_W-1:0]    o_x_c,
  output logic signed [XY_W-1:0]    o_y_c,
  output logic        [ANGLE_W-1:0] o_z_c
);

  logic signed [XY_W-1:0]    w_x_sh;
  logic signed [XY_W-1:0]    w_y_sh;
  logic        [ANGLE_W-1:0] w_atan;

  assign w_x_sh = i_x >>> i_shift;
  assign w_y_sh = i_y >>> i_shift;
  assign w_atan = atan_lut(i_shift);

  // Shift-and-add step using the pre-step x/y on both sides; z wraps naturally
  always_comb begin
    o_x_c = i_x;
    o_y_c = i_y;
    o_z_c = i_z;
    if (i_dir) begin
      o_x_c = i_x + w_y_sh;
      o_y_c = i_y - w_x_sh;
      o_z_c = i_z + w_atan;
    end else begin
      o_x_c = i_x - w_y_sh;
      o_y_c = i_y + w_x_sh;
      o_z_c = i_z - w_atan;
    end
  end

endmodule

// File: rtl/cordic_vectoring.sv
// Iterative vectoring-mode CORDIC: (x, y) -> gain-scaled magnitude and binary-angle atan2.
module cordic_vectoring
  import cordic_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned ITER  = 31
) (
  input logic              clk,
  input logic              rst,
  cordic_vectoring_if.slave io_bus
);

  localparam int unsigned        XY_W    = WIDTH + 2;
  localparam logic [SHIFT_W-1:0] LAST_IT = SHIFT_W'(ITER - 1);

  localparam logic [1:0] S_IDLE = 2'(ST_IDLE);
  localparam logic [1:0] S_ITER = 2'(ST_ITER);
  localparam logic [1:0] S_DONE = 2'(ST_DONE);

  logic [1:0]                r_state;
  logic [1:0]                w_state_nxt;
  logic signed [XY_W-1:0]    r_x;
  logic signed [XY_W-1:0]    w_x_nxt;
  logic signed [XY_W-1:0]    r_y;
  logic signed [XY_W-1:0]    w_y_nxt;
  logic [ANGLE_W-1:0]        r_z;
  logic [ANGLE_W-1:0]        w_z_nxt;
  logic [SHIFT_W-1:0]        r_iter;
  logic [SHIFT_W-1:0]        w_iter_nxt;
  logic                      r_zero;
  logic                      w_zero_nxt;
  logic                      r_in_ready;
  logic                      w_in_ready_nxt;
  logic                      r_out_valid;
  logic                      w_out_valid_nxt;
  logic [XY_W-1:0]           r_mag;
  logic [XY_W-1:0]           w_mag_nxt;
  logic [ANGLE_W-1:0]        r_angle;
  logic [ANGLE_W-1:0]        w_angle_nxt;

  logic signed [XY_W-1:0]    w_x_ext;
  logic signed [XY_W-1:0]    w_y_ext;
  logic signed [XY_W-1:0]    w_pre_x;
  logic signed [XY_W-1:0]    w_pre_y;
  logic [ANGLE_W-1:0]        w_pre_z;
  logic                      w_in_zero;
  logic signed [XY_W-1:0]    w_rot_x;
  logic signed [XY_W-1:0]    w_rot_y;
  logic [ANGLE_W-1:0]        w_rot_z;

  // Two guard bits so negating the most negative input and the CORDIC gain cannot overflow
  assign w_x_ext   = {{2{io_bus.x_in[WIDTH-1]}}, io_bus.x_in};
  assign w_y_ext   = {{2{io_bus.y_in[WIDTH-1]}}, io_bus.y_in};
  assign w_in_zero = (io_bus.x_in == '0) && (io_bus.y_in == '0);

  // Fold left-half-plane vectors into the right half plane by a +/-90 degree pre-rotation
  always_comb begin
    w_pre_x = w_x_ext;
    w_pre_y = w_y_ext;
    w_pre_z = '0;
    if (w_x_ext[XY_W-1]) begin
      if (!w_y_ext[XY_W-1]) begin
        w_pre_x = w_y_ext;
        w_pre_y = -w_x_ext;
        w_pre_z = QUAD_90;
      end else begin
        w_pre_x = -w_y_ext;
        w_pre_y = w_x_ext;
        w_pre_z = QUAD_270;
      end
    end
  end

  // Drive y toward zero: rotate clockwise while y is non-negative
  cordic_micro_rot #(
    .XY_W (XY_W)
  ) u_micro_rot (
    .i_x     (r_x),
    .i_y     (r_y),
    .i_z     (r_z),
    .i_shift (r_iter),
    .i_dir   (~r_y[XY_W-1]),
    .o_x_c   (w_rot_x),
    .o_y_c   (w_rot_y),
    .o_z_c   (w_rot_z)
  );

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt     = r_state;
    w_x_nxt         = r_x;
    w_y_nxt         = r_y;
    w_z_nxt         = r_z;
    w_iter_nxt      = r_iter;
    w_zero_nxt      = r_zero;
    w_in_ready_nxt  = r_in_ready;
    w_out_valid_nxt = r_out_valid;
    w_mag_nxt       = r_mag;
    w_angle_nxt     = r_angle;
    case (r_state)
      S_IDLE: begin
        if (io_bus.in_valid && r_in_ready) begin
          w_x_nxt        = w_pre_x;
          w_y_nxt        = w_pre_y;
          w_z_nxt        = w_pre_z;
          w_zero_nxt     = w_in_zero;
          w_iter_nxt     = '0;
          w_in_ready_nxt = 1'b0;
          w_state_nxt    = S_ITER;
        end
      end
      S_ITER: begin
        w_x_nxt = w_rot_x;
        w_y_nxt = w_rot_y;
        w_z_nxt = w_rot_z;
        if (r_iter == LAST_IT) begin
          w_state_nxt     = S_DONE;
          w_out_valid_nxt = 1'b1;
          w_mag_nxt       = w_rot_x;
          // A zero vector has no phase; without this z would drift to the table sum
          w_angle_nxt     = r_zero ? '0 : w_rot_z;
        end else begin
          w_iter_nxt = r_iter + 1'b1;
        end
      end
      S_DONE: begin
        if (io_bus.out_ready) begin
          w_out_valid_nxt = 1'b0;
          w_in_ready_nxt  = 1'b1;
          w_state_nxt     = S_IDLE;
        end
      end
      default: begin
        w_state_nxt     = S_IDLE;
        w_in_ready_nxt  = 1'b1;
        w_out_valid_nxt = 1'b0;
      end
    endcase
  end

  // State and output registers; reset discards any in-flight vector
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_x         <= '0;
      r_y         <= '0;
      r_z         <= '0;
      r_iter      <= '0;
      r_zero      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_mag       <= '0;
      r_angle     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_x         <= w_x_nxt;
      r_y         <= w_y_nxt;
      r_z         <= w_z_nxt;
      r_iter      <= w_iter_nxt;
      r_zero      <= w_zero_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_mag       <= w_mag_nxt;
      r_angle     <= w_angle_nxt;
    end
  end

  assign io_bus.in_ready  = r_in_ready;
  assign io_bus.out_valid = r_out_valid;
  assign io_bus.mag_out   = r_mag;
  assign io_bus.angle_out = r_angle;

endmodule
